// File: rtl/btb_assoc_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
// Optional feature macro: BTB_2BIT_CTR_EN (per-entry 2-bit direction counter).
package btb_assoc_pkg;

   // Widest tag any legal configuration can need; narrower tags are zero-extended.
   localparam int unsigned TAG_W_MAX = 32;

   // Counter value given to a freshly allocated entry (weakly taken).
   localparam logic [1:0] CTR_INIT = 2'b10;

   typedef struct packed {
      logic                 valid;
      logic [TAG_W_MAX-1:0] tag;
      logic [31:0]          target;
`ifdef BTB_2BIT_CTR_EN
      logic [1:0]           ctr;
`endif
   } btb_entry_t;

   // PLRU bits per set; a 1-way set keeps one dummy bit so the storage stays non-empty.
   function automatic int unsigned plru_width(input int unsigned ways);
      return (ways <= 1) ? 1 : ways - 1;
   endfunction

   // Bits needed to name a way.
   function automatic int unsigned way_width(input int unsigned ways);
      return (ways <= 2) ? 1 : $clog2(ways);
   endfunction

endpackage

// File: rtl/btb_plru.sv
// Per-set victim selection and MRU update for the BTB replacement policy.
module btb_plru
   import btb_assoc_pkg::*;
#(
   parameter int unsigned WAYS = 2,
   parameter int unsigned PW   = plru_width(WAYS),
   parameter int unsigned WW   = way_width(WAYS)
) (
   input  logic [PW-1:0]   plru_cur,
   input  logic [WAYS-1:0] valid_vec,
   input  logic [WW-1:0]   touch_way,
   output logic [WW-1:0]   victim_c,
   output logic [PW-1:0]   plru_next_c
);

   logic [WW-1:0] plru_victim;

   if (WAYS == 4) begin : g_tree
      // Root bit0 picks the LRU pair (0 = left); bit1/bit2 pick the LRU way inside each pair.
      always_comb begin
         plru_victim = plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]};
      end

      // Point every node on the touched path away from the touched way.
      always_comb begin
         plru_next_c    = plru_cur;
         plru_next_c[0] = ~touch_way[1];
         if (touch_way[1]) begin
            plru_next_c[2] = ~touch_way[0];
         end else begin
            plru_next_c[1] = ~touch_way[0];
         end
      end
   end else if (WAYS == 2) begin : g_pair
      // Single bit names the LRU way directly.
      always_comb begin
         plru_victim = plru_cur[0];
      end

      // The way not touched becomes LRU.
      always_comb begin
         plru_next_c = ~touch_way[0];
      end
   end else begin : g_direct
      // Direct-mapped: the only way is always the victim.
      always_comb begin
         plru_victim = '0;
      end

      // No replacement state to maintain.
      always_comb begin
         plru_next_c = plru_cur;
      end
   end

   // Lowest-numbered invalid way wins; otherwise fall back to the PLRU victim.
   always_comb begin
      victim_c = plru_victim;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_vec[w]) begin
            victim_c = WW'(w);
         end
      end
   end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative tagged branch target buffer: combinational lookup on the
// fetch PC, registered updates from the resolve stage, tree-PLRU replacement.
// Optional feature macro: BTB_2BIT_CTR_EN (2-bit saturating direction counter
// per entry; without it a not-taken hit invalidates the entry).
module btb_assoc
   import btb_assoc_pkg::*;
#(
   parameter int unsigned S_INDEX    = 6,
   parameter int unsigned WAYS       = 2,
   parameter int unsigned ADDR_START = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        predict_en,
   input  logic        flush,
   input  logic [31:0] curr_pc,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   output logic        hit,
   output logic        predict_taken,
   output logic [31:0] predicted_target
);

   localparam int unsigned NUM_SETS = 2 ** S_INDEX;
   localparam int unsigned TAG_LSB  = ADDR_START + S_INDEX;
   localparam int unsigned PW       = plru_width(WAYS);
   localparam int unsigned WW       = way_width(WAYS);

   btb_entry_t    mem    [NUM_SETS][WAYS];
   logic [PW-1:0] plru_q [NUM_SETS];

   logic [S_INDEX-1:0]   rd_idx;
   logic [TAG_W_MAX-1:0] rd_tag;
   logic [S_INDEX-1:0]   wr_idx;
   logic [TAG_W_MAX-1:0] wr_tag;
   logic                 upd_hit;
   logic [WW-1:0]        upd_way;
   logic [WAYS-1:0]      wr_valid_vec;
   logic [WW-1:0]        alloc_way;
   logic [WW-1:0]        touch_way;
   logic [PW-1:0]        plru_next;
   logic                 do_upd;
   logic                 unused_pc_lsbs;

   assign rd_idx = curr_pc[ADDR_START +: S_INDEX];
   assign rd_tag = TAG_W_MAX'(curr_pc[31:TAG_LSB]);
   assign wr_idx = upd_pc[ADDR_START +: S_INDEX];
   assign wr_tag = TAG_W_MAX'(upd_pc[31:TAG_LSB]);

   // Byte-offset bits below the index never select anything.
   assign unused_pc_lsbs = ^{curr_pc[ADDR_START-1:0], upd_pc[ADDR_START-1:0]};

   // Lookup: at most one way matches, so OR-ing the gated targets is a one-hot mux.
   always_comb begin
      hit              = 1'b0;
      predict_taken    = 1'b0;
      predicted_target = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (mem[rd_idx][w].valid && (mem[rd_idx][w].tag == rd_tag)) begin
            hit              = 1'b1;
            predicted_target = predicted_target | mem[rd_idx][w].target;
`ifdef BTB_2BIT_CTR_EN
            predict_taken    = predict_taken | mem[rd_idx][w].ctr[1];
`endif
         end
      end
`ifndef BTB_2BIT_CTR_EN
      predict_taken = hit;
`endif
   end

   // Resolve-side probe of the update set.
   always_comb begin
      upd_hit      = 1'b0;
      upd_way      = '0;
      wr_valid_vec = '0;
      for (int w = 0; w < WAYS; w++) begin
         wr_valid_vec[w] = mem[wr_idx][w].valid;
         if (mem[wr_idx][w].valid && (mem[wr_idx][w].tag == wr_tag)) begin
            upd_hit = 1'b1;
            upd_way = WW'(w);
         end
      end
   end

   assign touch_way = upd_hit ? upd_way : alloc_way;
   assign do_upd    = predict_en & upd_valid & ~flush;

   btb_plru #(
      .WAYS (WAYS)
   ) u_plru (
      .plru_cur    (plru_q[wr_idx]),
      .valid_vec   (wr_valid_vec),
      .touch_way   (touch_way),
      .victim_c    (alloc_way),
      .plru_next_c (plru_next)
   );

   // State update: reset beats flush beats resolve-stage write; stalls freeze everything but reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               mem[s][w].valid <= 1'b0;
`ifdef BTB_2BIT_CTR_EN
               mem[s][w].ctr   <= 2'b00;
`endif
            end
            plru_q[s] <= '0;
         end
      end else if (predict_en && flush) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               mem[s][w].valid <= 1'b0;
            end
            plru_q[s] <= '0;
         end
      end else if (do_upd) begin
         if (upd_hit) begin
            plru_q[wr_idx] <= plru_next;
`ifdef BTB_2BIT_CTR_EN
            if (upd_taken) begin
               mem[wr_idx][upd_way].target <= upd_target;
               if (mem[wr_idx][upd_way].ctr != 2'b11) begin
                  mem[wr_idx][upd_way].ctr <= mem[wr_idx][upd_way].ctr + 2'd1;
               end
            end else if (mem[wr_idx][upd_way].ctr != 2'b00) begin
               mem[wr_idx][upd_way].ctr <= mem[wr_idx][upd_way].ctr - 2'd1;
            end
`else
            if (upd_taken) begin
               mem[wr_idx][upd_way].target <= upd_target;
            end else begin
               mem[wr_idx][upd_way].valid  <= 1'b0;
            end
`endif
         end else if (upd_taken) begin
            mem[wr_idx][alloc_way].valid  <= 1'b1;
            mem[wr_idx][alloc_way].tag    <= wr_tag;
            mem[wr_idx][alloc_way].target <= upd_target;
`ifdef BTB_2BIT_CTR_EN
            mem[wr_idx][alloc_way].ctr    <= CTR_INIT;
`endif
            plru_q[wr_idx] <= plru_next;
         end
      end
   end

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc (default parameters: S_INDEX=6, WAYS=2, ADDR_START=2).
module tb_btb_assoc;

`ifdef BTB_2BIT_CTR_EN
   localparam bit CTR = 1'b1;
`else
   localparam bit CTR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        predict_en;
   logic        flush;
   logic [31:0] curr_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        hit;
   logic        predict_taken;
   logic [31:0] predicted_target;

   btb_assoc dut (
      .clk              (clk),
      .rst              (rst),
      .predict_en       (predict_en),
      .flush            (flush),
      .curr_pc          (curr_pc),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .hit              (hit),
      .predict_taken    (predict_taken),
      .predicted_target (predicted_target)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      bit          en;
      bit          flush;
      logic [31:0] pc;
      bit          uv;
      logic [31:0] upc;
      bit          ut;
      logic [31:0] utgt;
      bit          eh;
      bit          ep;
      logic [31:0] et;
      string       name;
   } vec_t;

   typedef struct {
      bit          h;
      bit          p;
      logic [31:0] t;
      string       name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void add(input bit r, input bit en, input bit fl, input logic [31:0] pc,
                               input bit uv, input logic [31:0] upc, input bit ut,
                               input logic [31:0] utgt, input bit eh, input bit ep,
                               input logic [31:0] et, input string name);
      vec_t v;
      v.rst = r; v.en = en; v.flush = fl; v.pc = pc;
      v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
      v.eh = eh; v.ep = ep; v.et = et; v.name = name;
      vecs.push_back(v);
   endfunction

   // Plain lookup, no update.
   function automatic void look(input logic [31:0] pc, input bit eh, input bit ep,
                                input logic [31:0] et, input string name);
      add(0, 1, 0, pc, 0, 32'h0, 0, 32'h0, eh, ep, et, name);
   endfunction

   // Lookup with a same-cycle resolve-stage update.
   function automatic void lupd(input logic [31:0] pc, input logic [31:0] upc, input bit ut,
                                input logic [31:0] utgt, input bit eh, input bit ep,
                                input logic [31:0] et, input string name);
      add(0, 1, 0, pc, 1, upc, ut, utgt, eh, ep, et, name);
   endfunction

   // Drive one cycle at negedge, queue the expectation, sample before the next posedge.
   task automatic apply(input vec_t v);
      exp_t e;
      @(negedge clk);
      rst        = v.rst;
      predict_en = v.en;
      flush      = v.flush;
      curr_pc    = v.pc;
      upd_valid  = v.uv;
      upd_pc     = v.upc;
      upd_taken  = v.ut;
      upd_target = v.utgt;
      e.h = v.eh; e.p = v.ep; e.t = v.et; e.name = v.name;
      sb.push_back(e);
      #2;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL %s: scoreboard empty", v.name);
      end else begin
         e = sb.pop_front();
         if (hit !== e.h || predict_taken !== e.p || predicted_target !== e.t) begin
            n_bad++;
            $display("FAIL %s: got hit=%b pt=%b tgt=%h, expected hit=%b pt=%b tgt=%h",
                     e.name, hit, predict_taken, predicted_target, e.h, e.p, e.t);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; predict_en = 1'b1; flush = 1'b0; curr_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
      repeat (2) @(negedge clk);

      // Set 0 holds pcs 0x100, 0x200, 0x300, ...; set 1 holds 0x104, 0x204, 0x304, ...
      look(32'h100, 0, 0, 32'h0, "reset_lookup");
      lupd(32'h100, 32'h100, 1, 32'h200, 0, 0, 32'h0, "alloc_same_cycle_miss");
      look(32'h100, 1, 1, 32'h200, "hit_after_alloc");
      look(32'h200, 0, 0, 32'h0, "alias_tag_miss");
      lupd(32'h300, 32'h300, 1, 32'h400, 0, 0, 32'h0, "upd_lookup_same_cycle");
      look(32'h300, 1, 1, 32'h400, "upd_visible_next");
      look(32'h100, 1, 1, 32'h200, "both_ways_hold");
      add(0, 0, 0, 32'h600, 1, 32'h600, 1, 32'h700, 0, 0, 32'h0, "en0_upd_cycle");
      look(32'h600, 0, 0, 32'h0, "en0_no_alloc");
      add(0, 0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 1, 1, 32'h200, "en0_flush_lookup");
      look(32'h100, 1, 1, 32'h200, "en0_flush_ignored");
      add(0, 1, 1, 32'h500, 1, 32'h500, 1, 32'h550, 0, 0, 32'h0, "flush_with_upd");
      look(32'h500, 0, 0, 32'h0, "flush_drops_upd");
      look(32'h100, 0, 0, 32'h0, "flush_clears_100");
      look(32'h300, 0, 0, 32'h0, "flush_clears_300");
      lupd(32'h800, 32'h800, 1, 32'h880, 0, 0, 32'h0, "nt_alloc");
      lupd(32'h800, 32'h800, 0, 32'h0, 1, 1, 32'h880, "nt_resolve_pre");
      look(32'h800, CTR, 1'b0, CTR ? 32'h880 : 32'h0, "nt_after");
      lupd(32'h800, 32'h800, 1, 32'h990, CTR, 1'b0, CTR ? 32'h880 : 32'h0, "nt_then_taken");
      look(32'h800, 1, 1, 32'h990, "taken_restores");
      lupd(32'h800, 32'h800, 0, 32'h0, 1, 1, 32'h990, "second_nt_pre");
      look(32'h800, CTR, 1'b0, CTR ? 32'h990 : 32'h0, "second_nt_after");
      lupd(32'h904, 32'h904, 0, 32'h0, 0, 0, 32'h0, "miss_nt_cycle");
      look(32'h904, 0, 0, 32'h0, "miss_nt_no_alloc");

      foreach (vecs[i]) apply(vecs[i]);
      vecs.delete();

      // Eviction: A, B, C share set 1; touching A between B and C makes B the victim.
      lupd(32'h104, 32'h104, 1, 32'hA00, 0, 0, 32'h0, "evict_alloc_A");
      lupd(32'h104, 32'h204, 1, 32'hB00, 1, 1, 32'hA00, "evict_alloc_B");
      lupd(32'h204, 32'h104, 1, 32'hA04, 1, 1, 32'hB00, "evict_touch_A");
      lupd(32'h104, 32'h304, 1, 32'hC00, 1, 1, 32'hA04, "evict_alloc_C");
      look(32'h104, 1, 1, 32'hA04, "evict_A_survives");
      look(32'h204, 0, 0, 32'h0, "evict_B_gone");
      look(32'h304, 1, 1, 32'hC00, "evict_C_hit");
      foreach (vecs[i]) apply(vecs[i]);
      vecs.delete();

      // Reset mid-operation discards the in-flight update and clears everything.
      add(1, 1, 0, 32'hA00, 1, 32'hA00, 1, 32'hAB0, 0, 0, 32'h0, "rst_with_upd");
      look(32'hA00, 0, 0, 32'h0, "rst_drops_upd");
      look(32'h104, 0, 0, 32'h0, "rst_clears_A");
      look(32'h304, 0, 0, 32'h0, "rst_clears_C");
      foreach (vecs[i]) apply(vecs[i]);

      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d leftover, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
